// File: rtl/mem_arbiter.sv
// Two-client arbiter for the shared memory port: data side has priority over fetch.
// Define ARB_STARVE_GUARD_EN to cap consecutive data grants while fetch is waiting.
module mem_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 128,
    parameter int MAX_D_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_read,
    output logic              i_resp,
    output logic [DATA_W-1:0] i_rdata,

    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_resp,
    output logic [DATA_W-1:0] d_rdata,

    output logic [ADDR_W-1:0] pmem_address,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [DATA_W-1:0] pmem_wdata,
    input  logic [DATA_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic i_req;
    logic d_req;
    logic streak_full;

    if (MAX_D_STREAK < 1) begin : g_bad_max_d_streak
        $error("mem_arbiter: MAX_D_STREAK must be at least 1");
    end

    assign i_req = i_read;
    assign d_req = d_read | d_write;

    // Read data is broadcast; each client qualifies it with its own resp.
    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        pmem_address = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_wdata   = '0;
        i_resp       = 1'b0;
        d_resp       = 1'b0;

        case (state)
            IDLE: begin
                // Ties go to data unless fetch has been passed over too often.
                if (d_req && !(i_req && streak_full)) begin
                    state_nxt = D_BUSY;
                end else if (i_req) begin
                    state_nxt = I_BUSY;
                end
            end

            I_BUSY: begin
                pmem_address = i_addr;
                pmem_read    = 1'b1;
                i_resp       = pmem_resp;
                if (pmem_resp) begin
                    state_nxt = IDLE;
                end
            end

            D_BUSY: begin
                pmem_address = d_addr;
                pmem_wdata   = d_wdata;
                pmem_write   = d_write;
                pmem_read    = d_read & ~d_write;
                d_resp       = pmem_resp;
                if (pmem_resp) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

`ifdef ARB_STARVE_GUARD_EN
    localparam int              CNT_W      = $clog2(MAX_D_STREAK + 1);
    localparam logic [CNT_W-1:0] STREAK_MAX = CNT_W'(MAX_D_STREAK);

    logic [CNT_W-1:0] d_streak;
    logic             grant_i;
    logic             grant_d;

    assign grant_i = (state == IDLE) && (state_nxt == I_BUSY);
    assign grant_d = (state == IDLE) && (state_nxt == D_BUSY);

    // Counts data grants that overtook a waiting fetch; saturates at the cap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_streak <= '0;
        end else if (grant_i || (grant_d && !i_req)) begin
            d_streak <= '0;
        end else if (grant_d && (d_streak != STREAK_MAX)) begin
            d_streak <= d_streak + CNT_W'(1);
        end
    end

    assign streak_full = (d_streak == STREAK_MAX);
`else
    assign streak_full = 1'b0;
`endif

    a_one_strobe: assert property (@(posedge clk) disable iff (!rst_n)
        !(pmem_read && pmem_write));

    a_one_resp: assert property (@(posedge clk) disable iff (!rst_n)
        !(i_resp && d_resp));

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios, then random clients and memory,
// all checked every cycle against a transaction-level ownership model.
module tb_mem_arbiter;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 128;
    localparam int MAXS   = 4;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic [ADDR_W-1:0] i_addr;
    logic              i_read;
    logic              i_resp;
    logic [DATA_W-1:0] i_rdata;
    logic [ADDR_W-1:0] d_addr;
    logic              d_read;
    logic              d_write;
    logic [DATA_W-1:0] d_wdata;
    logic              d_resp;
    logic [DATA_W-1:0] d_rdata;
    logic [ADDR_W-1:0] pmem_address;
    logic              pmem_read;
    logic              pmem_write;
    logic [DATA_W-1:0] pmem_wdata;
    logic [DATA_W-1:0] pmem_rdata;
    logic              pmem_resp;

    int total = 0;
    int bad   = 0;
    bit auto_mode = 1'b0;

    mem_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .MAX_D_STREAK(MAXS)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .i_addr(i_addr),
        .i_read(i_read),
        .i_resp(i_resp),
        .i_rdata(i_rdata),
        .d_addr(d_addr),
        .d_read(d_read),
        .d_write(d_write),
        .d_wdata(d_wdata),
        .d_resp(d_resp),
        .d_rdata(d_rdata),
        .pmem_address(pmem_address),
        .pmem_read(pmem_read),
        .pmem_write(pmem_write),
        .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata),
        .pmem_resp(pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Ownership model: who holds the port (0 none, 1 fetch, 2 data) and how
    // many data grants in a row have overtaken a waiting fetch.
    int                m_owner  = 0;
    int                m_streak = 0;
    logic [ADDR_W-1:0] e_addr;
    logic              e_rd;
    logic              e_wr;
    logic [DATA_W-1:0] e_wdata;
    logic              e_ir;
    logic              e_dr;
    bit                m_ireq;
    bit                m_dreq;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_owner  = 0;
            m_streak = 0;
        end
        e_addr  = '0;
        e_rd    = 1'b0;
        e_wr    = 1'b0;
        e_wdata = '0;
        e_ir    = 1'b0;
        e_dr    = 1'b0;
        if (m_owner == 1) begin
            e_addr = i_addr;
            e_rd   = 1'b1;
            e_ir   = pmem_resp;
        end else if (m_owner == 2) begin
            e_addr  = d_addr;
            e_wdata = d_wdata;
            e_wr    = d_write;
            e_rd    = d_read && !d_write;
            e_dr    = pmem_resp;
        end
        check("pmem_address", 128'(pmem_address), 128'(e_addr));
        check("pmem_read",    128'(pmem_read),    128'(e_rd));
        check("pmem_write",   128'(pmem_write),   128'(e_wr));
        check("i_resp",       128'(i_resp),       128'(e_ir));
        check("d_resp",       128'(d_resp),       128'(e_dr));
        check("i_rdata",      i_rdata,            pmem_rdata);
        check("d_rdata",      d_rdata,            pmem_rdata);
        if (m_owner != 1) begin
            check("pmem_wdata", pmem_wdata, e_wdata);
        end

        if (rst_n) begin
            if (m_owner == 0) begin
                m_ireq = i_read;
                m_dreq = d_read || d_write;
                if (m_dreq && !(m_ireq && GUARD && m_streak >= MAXS)) begin
                    m_owner  = 2;
                    m_streak = m_ireq ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
                end else if (m_ireq) begin
                    m_owner  = 1;
                    m_streak = 0;
                end
            end else if (pmem_resp) begin
                m_owner = 0;
            end
        end
    end

    // Random clients, memory and occasional reset, active after the directed part.
    bit i_seen;
    bit d_seen;
    bit in_op   = 1'b0;
    int lat     = 0;
    int rst_cnt = 0;
    int kind;

    task automatic new_d();
        kind    = int'($urandom_range(0, 3));
        d_read  = (kind <= 1) || (kind == 3);
        d_write = (kind >= 2);
        d_addr  = 16'($urandom);
        d_wdata = {$urandom, $urandom, $urandom, $urandom};
    endtask

    always begin
        @(negedge clk);
        i_seen = i_resp;
        d_seen = d_resp;
        @(posedge clk);
        #1;
        if (auto_mode) begin
            if (rst_cnt > 0) begin
                rst_cnt--;
                if (rst_cnt == 0) rst_n = 1'b1;
            end else if ($urandom_range(0, 399) == 0) begin
                rst_n   = 1'b0;
                rst_cnt = 2;
            end

            if (i_read && i_seen) begin
                if ($urandom_range(0, 1) == 1) i_read = 1'b0;
                else i_addr = 16'($urandom);
            end else if (!i_read && $urandom_range(0, 2) == 0) begin
                i_read = 1'b1;
                i_addr = 16'($urandom);
            end

            if ((d_read || d_write) && d_seen) begin
                if ($urandom_range(0, 1) == 1) begin
                    d_read  = 1'b0;
                    d_write = 1'b0;
                end else begin
                    new_d();
                end
            end else if (!(d_read || d_write) && $urandom_range(0, 2) == 0) begin
                new_d();
            end

            pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
            pmem_resp  = 1'b0;
            if (!rst_n) begin
                in_op = 1'b0;
            end else if (pmem_read || pmem_write) begin
                if (!in_op) begin
                    in_op = 1'b1;
                    lat   = int'($urandom_range(0, 3));
                end
                if (lat == 0) begin
                    pmem_resp = 1'b1;
                    in_op     = 1'b0;
                end else begin
                    lat--;
                end
            end
        end
    end

    initial begin
        rst_n      = 1'b0;
        i_addr     = '0;
        i_read     = 1'b0;
        d_addr     = '0;
        d_read     = 1'b0;
        d_write    = 1'b0;
        d_wdata    = '0;
        pmem_rdata = '0;
        pmem_resp  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst pmem_read",    128'(pmem_read),    128'(1'b0));
        check("rst pmem_write",   128'(pmem_write),   128'(1'b0));
        check("rst pmem_address", 128'(pmem_address), 128'(16'h0000));
        check("rst pmem_wdata",   pmem_wdata,         128'(0));
        check("rst i_resp",       128'(i_resp),       128'(1'b0));
        check("rst d_resp",       128'(d_resp),       128'(1'b0));

        // Lone fetch, memory answers three cycles after the strobe.
        rst_n  = 1'b1;
        i_read = 1'b1;
        i_addr = 16'h0040;
        #1 check("fetch idle cycle", 128'(pmem_read), 128'(1'b0));
        step();
        check("fetch strobe", 128'(pmem_read), 128'(1'b1));
        check("fetch addr", 128'(pmem_address), 128'(16'h0040));
        check("fetch no write", 128'(pmem_write), 128'(1'b0));
        step();
        step();
        step();
        pmem_rdata = {16{8'hA5}};
        pmem_resp  = 1'b1;
        #1;
        check("fetch i_resp", 128'(i_resp), 128'(1'b1));
        check("fetch i_rdata", i_rdata, {16{8'hA5}});
        check("fetch d_resp", 128'(d_resp), 128'(1'b0));
        step();
        pmem_resp = 1'b0;
        i_read    = 1'b0;
        #1 check("fetch back idle", 128'(pmem_read), 128'(1'b0));

        // Data write.
        d_write = 1'b1;
        d_addr  = 16'h1000;
        d_wdata = 128'h123456789ABCDEF0_0FEDCBA987654321;
        step();
        check("dwr write", 128'(pmem_write), 128'(1'b1));
        check("dwr read", 128'(pmem_read), 128'(1'b0));
        check("dwr addr", 128'(pmem_address), 128'(16'h1000));
        check("dwr wdata", pmem_wdata, 128'h123456789ABCDEF0_0FEDCBA987654321);
        step();
        pmem_resp = 1'b1;
        #1;
        check("dwr d_resp", 128'(d_resp), 128'(1'b1));
        check("dwr i_resp", 128'(i_resp), 128'(1'b0));

        // Simultaneous requests: data first, one idle cycle, then fetch.
        step();
        pmem_resp = 1'b0;
        d_write   = 1'b0;
        d_read    = 1'b1;
        d_addr    = 16'h2000;
        i_read    = 1'b1;
        i_addr    = 16'h0000;
        #1 check("tie idle", 128'(pmem_write), 128'(1'b0));
        step();
        check("tie d first", 128'(pmem_address), 128'(16'h2000));
        check("tie d read", 128'(pmem_read), 128'(1'b1));
        step();
        pmem_resp = 1'b1;
        #1 check("tie d_resp", 128'(d_resp), 128'(1'b1));
        step();
        pmem_resp = 1'b0;
        d_read    = 1'b0;
        #1 check("tie gap", 128'(pmem_read || pmem_write), 128'(1'b0));
        step();
        check("tie i next", 128'(pmem_read), 128'(1'b1));
        check("tie i addr", 128'(pmem_address), 128'(16'h0000));
        step();
        pmem_resp = 1'b1;
        #1 check("tie i_resp", 128'(i_resp), 128'(1'b1));
        step();
        pmem_resp = 1'b0;
        i_read    = 1'b0;

        // Both clients requesting continuously: watch the grant order.
        i_read = 1'b1;
        i_addr = 16'h0100;
        d_read = 1'b1;
        d_addr = 16'h0200;
        for (int g = 0; g < 6; g++) begin
            step();
            check("streak owner", 128'(pmem_address),
                  128'((GUARD && g == 4) ? 16'h0100 : 16'h0200));
            pmem_resp = 1'b1;
            step();
            pmem_resp = 1'b0;
            if (g == 5) begin
                i_read = 1'b0;
                d_read = 1'b0;
            end
            #1 check("streak gap", 128'(pmem_read || pmem_write), 128'(1'b0));
        end

        // Reset in the middle of a data write.
        d_write = 1'b1;
        d_addr  = 16'h3000;
        d_wdata = {4{32'hDEADBEEF}};
        step();
        check("rstmid write", 128'(pmem_write), 128'(1'b1));
        step();
        rst_n = 1'b0;
        #1;
        check("rstmid write drop", 128'(pmem_write), 128'(1'b0));
        check("rstmid read drop", 128'(pmem_read), 128'(1'b0));
        check("rstmid addr", 128'(pmem_address), 128'(16'h0000));
        d_write = 1'b0;
        i_read  = 1'b1;
        i_addr  = 16'h4000;
        step();
        check("rstmid held", 128'(pmem_read), 128'(1'b0));
        rst_n = 1'b1;
        step();
        check("rstmid regrant", 128'(pmem_read), 128'(1'b1));
        check("rstmid regrant addr", 128'(pmem_address), 128'(16'h4000));
        step();
        pmem_resp = 1'b1;
        #1 check("rstmid i_resp", 128'(i_resp), 128'(1'b1));
        step();
        pmem_resp = 1'b0;
        i_read    = 1'b0;

        // Read and write together count as a write.
        d_read  = 1'b1;
        d_write = 1'b1;
        d_addr  = 16'h5000;
        step();
        check("rdwr write", 128'(pmem_write), 128'(1'b1));
        check("rdwr read", 128'(pmem_read), 128'(1'b0));
        pmem_resp = 1'b1;
        #1 check("rdwr d_resp", 128'(d_resp), 128'(1'b1));
        step();
        pmem_resp = 1'b0;
        d_read    = 1'b0;
        d_write   = 1'b0;
        #1;
        auto_mode = 1'b1;

        repeat (4000) @(posedge clk);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-client arbiter that shares the single physical-memory port between the pipeline's instruction-fetch side (read-only) and data-access side (read/write). It sits between the I-side/D-side cache controllers and the physical memory model. Arbitration is registered, and a granted transaction is held until memory responds. Data requests have priority, with an optional starvation guard for fetch.

## Interface
- ADDR_W, 16, address width (lc3b_word).
- DATA_W, 128, line width transferred per transaction.
- MAX_D_STREAK, 4, consecutive D grants allowed while I waits (guard build only); must be ≥1.

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- i_addr  in  ADDR_W  fetch address
- i_read  in  1  fetch read request
- i_resp  out  1  fetch transaction complete; i_rdata valid this cycle
- i_rdata  out  DATA_W  fetch read data
- d_addr  in  ADDR_W  data address
- d_read  in  1  data read request
- d_write  in  1  data write request
- d_wdata  in  DATA_W  data write payload
- d_resp  out  1  data transaction complete
- d_rdata  out  DATA_W  data read data
- pmem_address  out  ADDR_W  memory address
- pmem_read  out  1  memory read strobe
- pmem_write  out  1  memory write strobe
- pmem_wdata  out  DATA_W  memory write payload
- pmem_rdata  in  DATA_W  memory read data
- pmem_resp  in  1  memory transaction complete

## Operation
- States: IDLE, I_BUSY, D_BUSY (registered). Reset: IDLE, streak counter 0.
- IDLE: pmem_read=pmem_write=0, pmem_address=0, pmem_wdata=0, i_resp=d_resp=0. Those values also hold throughout reset.
- IDLE transitions:
  - D pending (d_read|d_write) and I not pending -> D_BUSY.
  - I pending only -> I_BUSY.
  - Both pending -> D_BUSY, except under the guard rule (Configuration).
  - Neither pending -> stay in IDLE.
- I_BUSY: pmem_address=i_addr, pmem_read=1, pmem_write=0.
- D_BUSY: pmem_address=d_addr, pmem_wdata=d_wdata, pmem_write=d_write, pmem_read=d_read & ~d_write. If both d_read and d_write are asserted, the transaction is a write.
- In I_BUSY/D_BUSY: pmem_resp passes combinationally to the owner's resp. pmem_rdata passes to the owner's rdata. The non-owner's resp is 0.
- i_rdata/d_rdata carry pmem_rdata at all times; they are meaningful only with the matching resp.
- On pmem_resp in a BUSY state, the next state is IDLE. No direct BUSY->BUSY transition.
- Clients hold request, address and wdata stable until their resp. A request dropped before resp is a protocol violation; the arbiter remains in BUSY until pmem_resp regardless.
- Requests raised by the non-owner during BUSY wait; they are evaluated in IDLE.

## Timing
- Grant latency: request visible in IDLE at cycle n -> state changes at edge n/n+1 -> pmem strobe high in cycle n+1.
- Completion: pmem_resp in cycle k -> owner resp in cycle k (zero-cycle) -> IDLE in cycle k+1.
- Back-to-back: a request still asserted in cycle k+1 is granted at edge k+1/k+2. Minimum turnaround is 1 idle cycle between transactions.
- Reset asserted mid-transaction: state goes to IDLE immediately (async), strobes drop, streak clears. The in-flight memory operation is abandoned.

## Configuration
- ARB_STARVE_GUARD_EN defined:
  - Counter width is clog2(MAX_D_STREAK+1).
  - A D grant while I is pending increments the counter.
  - An I grant, or a D grant with I not pending, clears it.
  - In IDLE with both pending and counter == MAX_D_STREAK, I is granted.
  - The counter saturates and never wraps.
- Not defined: no counter; D always wins ties (strict priority).

## Test plan
- Lone fetch: i_read=1, i_addr=16'h0040; memory responds 3 cycles after strobe with rdata=128'hA5…A5 -> pmem_read high cycle 1, i_resp=1 with i_rdata=A5…A5 in the pmem_resp cycle, d_resp stays 0, state returns to IDLE.
- Data write: d_write=1, d_addr=16'h1000, d_wdata=128'h1234… -> pmem_write=1, pmem_read=0, pmem_address=16'h1000, d_resp pulses with pmem_resp.
- Simultaneous requests from IDLE (d_read@16'h2000, i_read@16'h0000) -> D served first, I granted at the edge after D completes, exactly 1 idle cycle between.
- Guard build, MAX_D_STREAK=4, I held high, D re-requesting continuously -> grant order D,D,D,D,I,D… The non-guard build never grants I while D keeps requesting.
- Reset asserted during D_BUSY before pmem_resp -> pmem_write and pmem_read drop in the same cycle, state=IDLE. After release, a pending i_read is granted in the normal one-cycle grant latency.
- d_read and d_write both high -> pmem_write=1, pmem_read=0.
